// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM encoding,
// operand/product widths and the round-robin pointer advance.
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } state_e;

    // Next round-robin start position after granting idx, wrapping modulo n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Request, response and multiplier buses of the multiplier-sharing controller.
// slave = controller side, master = requesters/consumer/multiplier side.
interface mul_share_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]                  req_valid;
    logic [NREQ-1:0]                  req_ready;
    logic [mul_pkg::MUL_W*NREQ-1:0]   req_x;
    logic [mul_pkg::MUL_W*NREQ-1:0]   req_y;
    logic [TAG_W*NREQ-1:0]            req_tag;

    logic                             resp_valid;
    logic                             resp_ready;
    logic [ID_W-1:0]                  resp_id;
    logic [TAG_W-1:0]                 resp_tag;
    logic [mul_pkg::PROD_W-1:0]       resp_z;
    logic                             resp_err;

    logic                             mul_start;
    logic [mul_pkg::MUL_W-1:0]        mul_x;
    logic [mul_pkg::MUL_W-1:0]        mul_y;
    logic                             mul_busy;
    logic [mul_pkg::PROD_W-1:0]       mul_z;

    modport slave (
        input  req_valid, req_x, req_y, req_tag, resp_ready, mul_busy, mul_z,
        output req_ready, resp_valid, resp_id, resp_tag, resp_z, resp_err,
               mul_start, mul_x, mul_y
    );

    modport master (
        output req_valid, req_x, req_y, req_tag, resp_ready, mul_busy, mul_z,
        input  req_ready, resp_valid, resp_id, resp_tag, resp_z, resp_err,
               mul_start, mul_x, mul_y
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after ptr,
// wrapping. Purely combinational so other shared-unit controllers can reuse it.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    gnt_any
);
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NREQ);
            if (!gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one sequential signed 32x32 multiplier among NREQ requesters:
// round-robin grant, one operation in flight, per-phase watchdog, tagged response.
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = 4,
    parameter int WDOG  = 64
) (
    input  logic             clk,
    input  logic             rst,
    mul_share_ctrl_if.slave  bus
);
    localparam int ID_W = $clog2(NREQ);
    localparam int WD_W = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [MUL_W-1:0]    x_q, x_d;
    logic [MUL_W-1:0]    y_q, y_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [PROD_W-1:0]   z_q, z_d;
    logic                err_q, err_d;

    logic [NREQ-1:0]     gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [NREQ-1:0]     req_ready;
    logic [WD_W-1:0]     wdog_inc;
    logic                wdog_expired;

    logic [MUL_W-1:0]    x_arr   [NREQ];
    logic [MUL_W-1:0]    y_arr   [NREQ];
    logic [TAG_W-1:0]    tag_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign x_arr[g]   = bus.req_x[g*MUL_W +: MUL_W];
        assign y_arr[g]   = bus.req_y[g*MUL_W +: MUL_W];
        assign tag_arr[g] = bus.req_tag[g*TAG_W +: TAG_W];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign wdog_inc     = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
    assign wdog_expired = (wdog_q >= WD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wdog_d    = wdog_q;
        x_d       = x_q;
        y_d       = y_q;
        tag_d     = tag_q;
        id_d      = id_q;
        z_d       = z_q;
        err_d     = err_q;
        req_ready = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A still-busy multiplier holds a stale operation; let it drain first.
                if (rst && gnt_any && !bus.mul_busy) begin
                    req_ready = gnt;
                    x_d       = x_arr[gnt_idx];
                    y_d       = y_arr[gnt_idx];
                    tag_d     = tag_arr[gnt_idx];
                    id_d      = gnt_idx;
                    ptr_d     = ID_W'(rr_next(int'(gnt_idx), NREQ));
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.mul_busy) begin
                    wdog_d  = '0;
                    state_d = ST_WAIT_DONE;
                end else if (wdog_expired) begin
                    z_d     = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.mul_busy) begin
                    z_d     = bus.mul_z;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wdog_expired) begin
                    z_d     = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            ST_RESP: begin
                wdog_d = '0;
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            wdog_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            tag_q   <= '0;
            id_q    <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tag_q   <= tag_d;
            id_q    <= id_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_id    = id_q;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_z     = z_q;
    assign bus.resp_err   = err_q;
    assign bus.mul_start  = (state_q == ST_ISSUE);
    assign bus.mul_x      = x_q;
    assign bus.mul_y      = y_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: behavioural multiplier plus a
// scoreboard of expected responses filled when requests are staged.
module tb_mul_share_ctrl;
    import mul_pkg::*;

    localparam int NREQ  = 4;
    localparam int TAG_W = 4;
    localparam int WDOG  = 64;

    typedef struct {
        int               id;
        logic [TAG_W-1:0] tag;
        logic [63:0]      z;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_share_ctrl_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

    mul_share_ctrl #(.NREQ(NREQ), .TAG_W(TAG_W), .WDOG(WDOG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    logic [NREQ-1:0] stage_valid = '0;
    logic [NREQ-1:0] clr_pend    = '0;
    logic            rr_next_v   = 1'b1;

    // Behavioural multiplier: busy rises the edge after start, falls mul_lat edges later.
    logic        busy_m   = 1'b0;
    logic [63:0] z_m      = '0;
    int          cnt_m    = 0;
    int          mul_lat  = 5;
    bit          mul_dead = 1'b0;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    always @(posedge clk) begin
        if (cnt_m > 0) begin
            cnt_m <= cnt_m - 1;
            if (cnt_m == 1) begin
                busy_m <= 1'b0;
                z_m    <= smul(bus.mul_x, bus.mul_y);
            end
        end else if (bus.mul_start && !mul_dead) begin
            busy_m <= 1'b1;
            cnt_m  <= mul_lat;
        end
    end

    assign bus.mul_busy = busy_m;
    assign bus.mul_z    = z_m;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: apply staged inputs at the falling edge, then sample and score.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        bus.req_valid  = (bus.req_valid & ~clr_pend) | stage_valid;
        stage_valid    = '0;
        bus.resp_ready = rr_next_v;
        #1;
        clr_pend = bus.req_valid & bus.req_ready;
        if (bus.req_ready != '0) begin
            check("rdy_onehot", 64'($countones(bus.req_ready)), 64'd1);
            check("rdy_needs_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
        end
        if (bus.resp_valid && bus.resp_ready) begin
            check("sb_nonempty", 64'(sb_q.size() == 0), 64'd0);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("resp_id",  64'(bus.resp_id),  64'(e.id));
                check("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
                check("resp_z",   bus.resp_z,        e.z);
                check("resp_err", 64'(bus.resp_err), 64'(e.err));
            end
        end
    endtask

    task automatic request(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic [TAG_W-1:0] tag, input logic [63:0] z, input logic err);
        exp_t e;
        bus.req_x[i*32 +: 32]       = x;
        bus.req_y[i*32 +: 32]       = y;
        bus.req_tag[i*TAG_W +: TAG_W] = tag;
        stage_valid[i] = 1'b1;
        e.id  = i;
        e.tag = tag;
        e.z   = z;
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready",  64'(bus.req_ready),  64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_id",    64'(bus.resp_id),    64'd0);
        check("rst_resp_tag",   64'(bus.resp_tag),   64'd0);
        check("rst_resp_z",     bus.resp_z,          64'd0);
        check("rst_resp_err",   64'(bus.resp_err),   64'd0);
        check("rst_mul_start",  64'(bus.mul_start),  64'd0);
        check("rst_mul_x",      64'(bus.mul_x),      64'd0);
        check("rst_mul_y",      64'(bus.mul_y),      64'd0);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (chk) check_reset_vals();
        bus.req_valid = '0;
        stage_valid   = '0;
        clr_pend      = '0;
        sb_q.delete();
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || bus.resp_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] rx, ry;
        int ri;

        rst            = 1'b0;
        bus.req_valid  = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
        do_reset(1'b1);

        // All four valid together: grants 0,1,2,3 with products 2,4,6,8.
        for (int i = 0; i < NREQ; i++)
            request(i, 32'(i + 1), 32'd2, TAG_W'(i + 8), 64'(2 * (i + 1)), 1'b0);
        drain(400);

        // Single request with latency checks.
        request(0, 32'd7, 32'hFFFF_FFFD, 4'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!clr_pend[0] && n < 50);
        check("grant0", 64'(clr_pend[0]), 64'd1);
        tick();
        check("start_pulse", 64'(bus.mul_start), 64'd1);
        tick();
        check("start_once", 64'(bus.mul_start), 64'd0);
        n = 0;
        while (bus.mul_busy && n < 50) begin
            tick();
            n++;
        end
        check("busy_fell", 64'(bus.mul_busy), 64'd0);
        check("valid_not_early", 64'(bus.resp_valid), 64'd0);
        tick();
        check("valid_after_fall", 64'(bus.resp_valid), 64'd1);
        drain(100);

        // Extreme operands; pointer is at 1 so requester 1 goes first.
        request(1, 32'h8000_0000, 32'h8000_0000, 4'd3, 64'h4000_0000_0000_0000, 1'b0);
        request(2, 32'hFFFF_FFFF, 32'd1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drain(200);

        // Backpressure: response held 20 cycles, no grant meanwhile.
        do_reset(1'b0);
        rr_next_v = 1'b0;
        request(2, 32'd100, 32'hFFFF_FFF9, 4'd9, 64'hFFFF_FFFF_FFFF_FD44, 1'b0);
        request(3, 32'd6, 32'd7, 4'd10, 64'd42, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.resp_valid && n < 100);
        for (int k = 0; k < 20; k++) begin
            check("bp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_id",    64'(bus.resp_id),    64'd2);
            check("bp_tag",   64'(bus.resp_tag),   64'd9);
            check("bp_z",     bus.resp_z,          64'hFFFF_FFFF_FFFF_FD44);
            check("bp_no_grant", 64'(bus.req_ready), 64'd0);
            tick();
        end
        rr_next_v = 1'b1;
        drain(200);

        // Random single operations.
        for (int k = 0; k < 6; k++) begin
            ri = $urandom_range(0, NREQ - 1);
            rx = $urandom;
            ry = $urandom;
            request(ri, rx, ry, TAG_W'(k), smul(rx, ry), 1'b0);
            drain(100);
        end

        // Watchdog: multiplier never goes busy.
        do_reset(1'b0);
        mul_dead = 1'b1;
        request(0, 32'd5, 32'd6, 4'd7, 64'd0, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.mul_start && n < 20);
        check("wdog_start", 64'(bus.mul_start), 64'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.resp_valid && n < 300);
        check("wdog_latency", 64'(n), 64'(WDOG + 1));
        drain(20);
        mul_dead = 1'b0;
        request(1, 32'd11, 32'hFFFF_FFFC, 4'd8, 64'hFFFF_FFFF_FFFF_FFD4, 1'b0);
        drain(100);

        // Reset while waiting for the multiplier; stale busy must drain first.
        mul_lat = 30;
        request(1, 32'd9, 32'd9, 4'd2, 64'd81, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.mul_busy && n < 20);
        repeat (3) tick();
        do_reset(1'b1);
        mul_lat = 5;
        request(3, 32'd12, 32'd13, 4'd6, 64'd156, 1'b0);
        tick();
        n = 0;
        while (bus.mul_busy && n < 100) begin
            check("stale_no_grant", 64'(bus.req_ready), 64'd0);
            tick();
            n++;
        end
        check("stale_drained", 64'(bus.mul_busy), 64'd0);
        drain(100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
